serial_sub_op: RTL
==================

Name: serial_sub_op

Overview:
- Sequential 4-bit unsigned subtractor; the inverse operation of the team's combinational adder.
- Computes num1 - num2 bit-serially, LSB first, through a single full-subtractor cell and a registered borrow flop.
- Uses a start/busy/done handshake and produces a 5-bit result: difference plus borrow/underflow flag in the MSB, the same packing as the adder's carry-out.
- Sits beside the adder in the processor's ALU. The control FSM issues start and waits for done.

Parameters:
- WIDTH, 4, operand width in bits; also the number of SUB cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- num1  input  WIDTH  minuend; captured on accepted start.
- num2  input  WIDTH  subtrahend; captured on accepted start.
- busy  output  1  high while state is SUB.
- done  output  1  one-cycle pulse; result valid from this cycle.
- result  output  WIDTH+1  [WIDTH-1:0] = (num1-num2) mod 2^WIDTH; [WIDTH] = borrow (1 iff num1 < num2, unsigned).

Behaviour:
- Clock is clk. Reset rst is synchronous, active-high, one clock domain.
- Reset values:
  - state = IDLE.
  - busy = 0, done = 0, result = 0.
  - Internal operand shift registers, difference register, borrow flop and bit counter = 0.
- Reset mid-operation: aborts immediately. No done pulse; result returns to 0.
- States:
  - IDLE:
    - busy = 0, done = 0.
    - If start=1 at an edge: latch num1/num2 into shift registers, clear borrow and counter, go to SUB.
  - SUB:
    - busy = 1. Each edge consumes one bit pair a = opA[0], b = opB[0].
    - d = a ^ b ^ bw.
    - bw_next = (~a & b) | (~(a ^ b) & bw).
    - Shift opA and opB right. Shift d into the difference register from the MSB side. Counter increments.
    - When counter reaches WIDTH-1 at an edge, load result = {bw_next, final difference} and go to DONE.
  - DONE:
    - done = 1, busy = 0, for exactly one cycle.
    - start is ignored in this state. Next state is IDLE.
- Latency: start sampled at edge E0. SUB covers edges E1..E(WIDTH). done is high in the cycle after edge E0+WIDTH, i.e. 5 cycles for WIDTH=4. Throughput is one operation per WIDTH+2 cycles.
- start while busy or done: ignored. Operands are not re-latched and no queueing occurs.
- num1/num2 may change freely after the accepting edge without affecting the operation in flight.
- result holds its last value until the next operation completes. It is not cleared on start.
- Wrap-around: the difference is modulo 2^WIDTH. Borrow out of the MSB appears only in result[WIDTH].
- start held high continuously: a new operation is accepted each time IDLE is reached, giving back-to-back operations with the same period.

Decomposition:
- Package sub_pkg:
  - state_t enum {IDLE, SUB, DONE}.
  - Localparam default width 4.
  - Counter-width helper ($clog2(WIDTH)).
- Sub-module full_subtractor: 1-bit combinational cell.
  - Inputs a, b, bin. Outputs d, bout.
  - Instantiated once in serial_sub_op.
  - Mirrors the adder's per-bit full-adder equations.

Test Plan:
- Reset, then num1=9, num2=3, start pulse -> busy for 4 cycles; done pulse 5 cycles after the start edge; result=5'b0_0110.
- num1=3, num2=9 -> result=5'b1_1010 (borrow set, difference 0xA); num1=0, num2=1 -> result=5'b1_1111.
- Boundaries: 15-15 -> 5'b0_0000; 15-0 -> 5'b0_1111; 0-0 -> 5'b0_0000; 0-15 -> 5'b1_0001.
- Start 7-2; pulse start with 1-1 during SUB and during DONE, and change num1/num2 mid-operation -> single done, result=5'b0_0101, no second operation.
- Assert rst on the 2nd SUB cycle -> next cycle busy=0, done=0, result=0, state IDLE; a subsequent 12-5 completes normally with result=5'b0_0111.
- Hold start=1 with operands 10-4 -> done pulses every 6 cycles, each with result=5'b0_0110. Exhaustive random sweep of all 256 pairs checked against a num1-num2 reference model.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared types and helpers for the serial subtractor.
// State encoding and counter sizing live here so the top and bench agree.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_op_if.sv
// start/busy/done bundle between the ALU control FSM and the subtractor.
// The controller is the master; the subtractor is the slave.
interface serial_sub_op_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   result;

    modport master (
        output start, num1, num2,
        input  busy, done, result
    );

    modport slave (
        input  start, num1, num2,
        output busy, done, result
    );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
// Same shape as the adder's per-bit full-adder equations.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_sub_op.sv
// Bit-serial unsigned subtractor, LSB first, one full-subtractor cell.
// result = {borrow, num1 - num2 mod 2^WIDTH}, valid from the done pulse.
module serial_sub_op
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    serial_sub_op_if.slave bus
);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           nxt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   res;
    logic [CW-1:0]    cnt;
    logic             bw;
    logic             d;
    logic             bout;

    full_subtractor u_fs (
        .a    (opa[0]),
        .b    (opb[0]),
        .bin  (bw),
        .d    (d),
        .bout (bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (bus.start) nxt = SUB;
            SUB:     if (cnt == LAST) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa  <= '0;
            opb  <= '0;
            diff <= '0;
            res  <= '0;
            cnt  <= '0;
            bw   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        opa <= bus.num1;
                        opb <= bus.num2;
                        bw  <= 1'b0;
                        cnt <= '0;
                    end
                end
                SUB: begin
                    opa  <= opa >> 1;
                    opb  <= opb >> 1;
                    diff <= {d, diff[WIDTH-1:1]};
                    bw   <= bout;
                    cnt  <= cnt + 1'b1;
                    // final bit lands directly in the result, skipping diff
                    if (cnt == LAST) begin
                        res <= {bout, d, diff[WIDTH-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy   = (state == SUB);
    assign bus.done   = (state == DONE);
    assign bus.result = res;
endmodule
